i2c_master_burst: RTL
=====================

I2C_MASTER_BURST -- requirements
Module: i2c_master_burst

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  DIV_W      7   width of divisor input
  MAX_BYTES  4   maximum data bytes per transaction
  CNT_W      3   width of nbytes; SHALL satisfy 2**CNT_W > MAX_BYTES
REQ-002 Ports, one per line (name  direction  width  meaning):
  clk        in     1            system clock
  reset      in     1            synchronous, active-high reset
  divisor    in     DIV_W        quarter-SCL period minus 1, in clk cycles
  start      in     1            one-cycle request; accepted only when busy=0
  rw         in     1            0 = write, 1 = read
  dev_addr   in     7            7-bit slave address
  reg_addr   in     8            slave register pointer
  nbytes     in     CNT_W        data byte count
  wdata      in     8*MAX_BYTES  write payload; byte k = wdata[8k+7:8k]
  rdata      out    8*MAX_BYTES  read payload; byte k = rdata[8k+7:8k]
  busy       out    1            transaction in progress
  done       out    1            one-cycle completion pulse
  ack_err    out    1            last transaction aborted on slave NACK
  i2c_sclk   out    1            SCL, driven push-pull
  i2c_sdat   inout  1            SDA, open-drain: drives 0 or Z only
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 Accepting start with busy=0 SHALL latch rw, dev_addr, reg_addr, nbytes, wdata and divisor; busy SHALL assert on the next cycle.
REQ-005 start while busy=1 SHALL be ignored, with no change to the latched values.
REQ-006 Tick generator SHALL produce one tick every divisor+1 clk cycles; one SCL bit SHALL equal 4 ticks (SCL low for ticks 0-1, high for ticks 2-3).
REQ-007 divisor=0 SHALL be legal and give an SCL period of 4 clk cycles.
REQ-008 SDA SHALL change only at tick 0 of a bit; the slave bit SHALL be sampled at tick 2.
REQ-009 Field order SHALL be: byte order byte 0 first; MSB first within each byte.
REQ-010 FSM states: IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_W, RSTART, ADDR_R, ACK_AR, RDATA, MACK, STOP.
REQ-011 Write sequence (rw=0): START, {dev_addr,0}, ACK, reg_addr, ACK, then nbytes x (WDATA, ACK_W), then STOP.
REQ-012 Read sequence (rw=1): START, {dev_addr,0}, ACK, reg_addr, ACK, RSTART, {dev_addr,1}, ACK, then nbytes x (RDATA, MACK), then STOP.
REQ-013 In MACK the master SHALL drive ACK (0) after each read byte except the last; after the last byte it SHALL release SDA (NACK).
REQ-014 START: SDA falls while SCL high. RSTART: SDA released, SCL high, then SDA falls. STOP: SDA rises while SCL high.
REQ-015 nbytes=0 SHALL perform the address + reg_addr phases only, then STOP, regardless of rw.
REQ-016 nbytes>MAX_BYTES SHALL be clamped to MAX_BYTES.
REQ-017 Slave NACK (SDA=1 sampled) in any ACK state SHALL go to STOP, set ack_err=1, and still pulse done.
REQ-018 ack_err SHALL clear when the next start is accepted.
REQ-019 On completion of STOP, busy SHALL deassert and done SHALL pulse for exactly 1 cycle in the same cycle.
REQ-020 rdata SHALL update only for received bytes; unreceived bytes SHALL hold their previous values.
REQ-021 While IDLE, i2c_sclk SHALL be 1 and i2c_sdat SHALL be Z.

Reset
REQ-022 Reset SHALL give: i2c_sclk=1, i2c_sdat=Z, busy=0, done=0, ack_err=0, rdata=0, FSM=IDLE, tick counter=0.
REQ-023 Reset asserted mid-transaction SHALL release SDA and drive SCL high on the next cycle, with no STOP generated and no done pulse.

Verification
REQ-024 Write, divisor=1, dev_addr=0x50, reg_addr=0x10, nbytes=2, wdata=0x..BBAA, slave ACKs all -> bus carries 0xA0, 0x10, 0xAA, 0xBB; busy high for 8*(1+36)+16 cycles ±8; done pulses once; ack_err=0.
REQ-025 Read, nbytes=3, slave returns 0x11, 0x22, 0x33 -> rdata[23:0]=0x332211; master ACK, ACK, NACK; second address byte 0xA1.
REQ-026 Slave NACKs the address byte -> STOP follows immediately; ack_err=1; done pulses; no reg_addr bits driven.
REQ-027 start pulsed during busy, then nbytes=0 -> first transaction is unaffected; second transaction sends only address + register, then STOP.
REQ-028 reset asserted during WDATA -> next cycle i2c_sclk=1, SDA=Z, busy=0, no done pulse; a following transaction completes normally.
REQ-029 divisor=0 -> SCL period of 4 clk cycles; SDA is stable whenever SCL is high, except during START/RSTART/STOP.

Source files
------------

// File: rtl/i2c_master_burst.sv
// I2C master: register-addressed burst write or read of up to MAX_BYTES bytes.
// SCL is built from four ticks per bit; each tick lasts divisor+1 clk cycles.
module i2c_master_burst #(
    parameter int DIV_W     = 7,
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIV_W-1:0]       divisor,
    input  logic                   start,
    input  logic                   rw,
    input  logic [6:0]             dev_addr,
    input  logic [7:0]             reg_addr,
    input  logic [CNT_W-1:0]       nbytes,
    input  logic [8*MAX_BYTES-1:0] wdata,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_err,
    output logic                   i2c_sclk,
    inout  wire                    i2c_sdat
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_W,
        RSTART, ADDR_R, ACK_AR, RDATA, MACK, STOP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic [1:0]             ph_q, ph_d;
    logic [2:0]             bit_q, bit_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   nack_q, nack_d;
    logic [8*MAX_BYTES-1:0] rdata_q, rdata_d;
    logic                   ack_err_q, ack_err_d;
    logic                   done_q, done_d;
    logic [DIV_W-1:0]       divisor_q, divisor_d;
    logic                   rw_q, rw_d;
    logic [6:0]             dev_q, dev_d;
    logic [7:0]             reg_q, reg_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [8*MAX_BYTES-1:0] wdata_q, wdata_d;

    logic tick, sample, bit_end, last, sda_in, scl, sda_low;
    logic [CNT_W-1:0] idx_nxt;

    assign sda_in  = i2c_sdat;
    assign tick    = (state_q != IDLE) && (div_cnt_q == divisor_q);
    assign sample  = tick && (ph_q == 2'd2);
    assign bit_end = tick && (ph_q == 2'd3);
    assign last    = (idx_q == n_q - CNT_ONE);
    assign idx_nxt = idx_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        divisor_d = divisor_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        n_d       = n_q;
        wdata_d   = wdata_q;
        if (state_q == IDLE) begin
            div_cnt_d = '0;
            ph_d      = '0;
            if (start) begin
                divisor_d = divisor;
                rw_d      = rw;
                dev_d     = dev_addr;
                reg_d     = reg_addr;
                n_d       = (nbytes > CNT_MAX) ? CNT_MAX : nbytes;
                wdata_d   = wdata;
                ack_err_d = 1'b0;
                state_d   = START;
            end
        end else begin
            if (tick) begin
                div_cnt_d = '0;
                ph_d      = ph_q + 2'd1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
            // Slave-driven bits are captured mid-way through SCL high.
            if (sample) begin
                nack_d = sda_in;
                if (state_q == RDATA) shift_d = {shift_q[6:0], sda_in};
            end
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_d = ADDR_W;
                        shift_d = {dev_q, 1'b0};
                        bit_d   = '0;
                    end
                    ADDR_W, REG, WDATA, ADDR_R: begin
                        if (bit_q == 3'd7) begin
                            case (state_q)
                                ADDR_W:  state_d = ACK_A;
                                REG:     state_d = ACK_R;
                                WDATA:   state_d = ACK_W;
                                default: state_d = ACK_AR;
                            endcase
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            bit_d   = bit_q + 3'd1;
                        end
                    end
                    ACK_A: begin
                        if (nack_q) begin
                            state_d   = STOP;
                            ack_err_d = 1'b1;
                        end else begin
                            state_d = REG;
                            shift_d = reg_q;
                            bit_d   = '0;
                        end
                    end
                    ACK_R: begin
                        if (nack_q) begin
                            state_d   = STOP;
                            ack_err_d = 1'b1;
                        end else if (n_q == '0) begin
                            state_d = STOP;
                        end else if (rw_q) begin
                            state_d = RSTART;
                        end else begin
                            state_d = WDATA;
                            shift_d = wdata_q[7:0];
                            idx_d   = '0;
                            bit_d   = '0;
                        end
                    end
                    ACK_W: begin
                        if (nack_q) begin
                            state_d   = STOP;
                            ack_err_d = 1'b1;
                        end else if (last) begin
                            state_d = STOP;
                        end else begin
                            state_d = WDATA;
                            idx_d   = idx_nxt;
                            shift_d = wdata_q[8*idx_nxt +: 8];
                            bit_d   = '0;
                        end
                    end
                    RSTART: begin
                        state_d = ADDR_R;
                        shift_d = {dev_q, 1'b1};
                        bit_d   = '0;
                    end
                    ACK_AR: begin
                        if (nack_q) begin
                            state_d   = STOP;
                            ack_err_d = 1'b1;
                        end else begin
                            state_d = RDATA;
                            idx_d   = '0;
                            bit_d   = '0;
                        end
                    end
                    RDATA: begin
                        if (bit_q == 3'd7) begin
                            state_d = MACK;
                            for (int k = 0; k < MAX_BYTES; k++) begin
                                if (idx_q == CNT_W'(k)) rdata_d[8*k +: 8] = shift_q;
                            end
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    MACK: begin
                        if (last) begin
                            state_d = STOP;
                        end else begin
                            state_d = RDATA;
                            idx_d   = idx_nxt;
                            bit_d   = '0;
                        end
                    end
                    STOP: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // START/RSTART/STOP move SDA while SCL is high; data bits change only at phase 0.
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            IDLE: begin
            end
            START: sda_low = ph_q[1];
            RSTART: begin
                scl     = ph_q[1];
                sda_low = (ph_q == 2'd3);
            end
            STOP: begin
                scl     = ph_q[1];
                sda_low = (ph_q != 2'd3);
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
                scl     = ph_q[1];
                sda_low = ~shift_q[7];
            end
            MACK: begin
                scl     = ph_q[1];
                sda_low = ~last;
            end
            default: scl = ph_q[1];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            ph_q      <= '0;
            rdata_q   <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            ph_q      <= ph_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        bit_q     <= bit_d;
        idx_q     <= idx_d;
        shift_q   <= shift_d;
        nack_q    <= nack_d;
        divisor_q <= divisor_d;
        rw_q      <= rw_d;
        dev_q     <= dev_d;
        reg_q     <= reg_d;
        n_q       <= n_d;
        wdata_q   <= wdata_d;
    end

    assign rdata    = rdata_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ack_err  = ack_err_q;
    assign i2c_sclk = scl;
    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
endmodule
